// File: rtl/multi_cycle_adder.sv
// rtl/multi_cycle_adder.sv - digit-serial WIDTH-bit adder, DIGIT bits per clock, valid/ready handshake
//
// Adds A + B + Cin over NSLICE = WIDTH/DIGIT cycles, least significant slice
// first. The carry between slices is held in a register.
//
// Optional feature macro: MULTI_CYCLE_ADDER_OVF_EN adds output V, the signed
// two's-complement overflow of the completed sum.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  operand handshake (A, B, Cin)
//   A, B, Cin           operands and carry-in to bit 0
//   out_valid, out_ready result handshake (S, Cout[, V])
//   S, Cout             registered sum and carry-out
//   V                   signed overflow (only with MULTI_CYCLE_ADDER_OVF_EN)

module multi_cycle_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef MULTI_CYCLE_ADDER_OVF_EN
    ,
    output logic             V
`endif
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic             carry_q,     carry_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [WIDTH-1:0] s_q,         s_d;
    logic             cout_q,      cout_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             v_q,         v_d;

    logic [DIGIT-1:0] a_slice;
    logic [DIGIT-1:0] b_slice;
    logic [DIGIT:0]   slice_sum;
    int unsigned      base;

    // Current slice operands and their DIGIT+1-bit sum including the carry reg
    always_comb begin
        base      = int'(cnt_q) * DIGIT;
        a_slice   = a_q[base +: DIGIT];
        b_slice   = b_q[base +: DIGIT];
        slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{DIGIT{1'b0}}, carry_q};
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        s_d         = s_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        v_d         = v_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = A;
                    b_d        = B;
                    carry_d    = Cin;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = ADD;
                end
            end
            ADD: begin
                s_d[base +: DIGIT] = slice_sum[DIGIT-1:0];
                carry_d            = slice_sum[DIGIT];
                if (cnt_q == LAST) begin
                    cout_d      = slice_sum[DIGIT];
                    // Carry into the MSB is recovered from the MSB's sum bit
                    // and its operand bits; overflow is that XOR carry-out.
                    v_d         = slice_sum[DIGIT-1] ^ a_q[WIDTH-1] ^ b_q[WIDTH-1]
                                  ^ slice_sum[DIGIT];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            v_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            s_q         <= s_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            v_q         <= v_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign Cout      = cout_q;
`ifdef MULTI_CYCLE_ADDER_OVF_EN
    assign V         = v_q;
`else
    // Overflow flop has no load without the V port and is removed in synthesis
    logic unused_v;
    assign unused_v  = v_q;
`endif

endmodule

// File: tb/tb_multi_cycle_adder.sv
// tb/tb_multi_cycle_adder.sv - scoreboard bench for multi_cycle_adder at DIGIT 4, 16 and 1

module tb_multi_cycle_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        Cin = 1'b0;

    // Instance 0: DIGIT=4, instance 1: DIGIT=16, instance 2: DIGIT=1
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [15:0] s         [3];
    logic        cout      [3];
`ifdef MULTI_CYCLE_ADDER_OVF_EN
    logic        v         [3];
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [17:0] sb_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        multi_cycle_adder #(
            .WIDTH(16),
            .DIGIT(g == 0 ? 4 : (g == 1 ? 16 : 1))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .A        (A),
            .B        (B),
            .Cin      (Cin),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .S        (s[g]),
            .Cout     (cout[g])
`ifdef MULTI_CYCLE_ADDER_OVF_EN
            ,
            .V        (v[g])
`endif
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int nslice(input int g);
        return (g == 0) ? 4 : ((g == 1) ? 1 : 16);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] observed(input int g);
        logic ov;
        ov = 1'b0;
`ifdef MULTI_CYCLE_ADDER_OVF_EN
        ov = v[g];
`endif
        return {ov, cout[g], s[g]};
    endfunction

    task automatic run_op(input int g, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input int hold);
        logic [16:0] full;
        logic [17:0] e;
        logic [17:0] got;
        logic        ovf;
        logic        busy_bad;
        logic        hold_bad;
        int          lat;
        full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        ovf  = 1'b0;
`ifdef MULTI_CYCLE_ADDER_OVF_EN
        ovf  = (a[15] == b[15]) && (full[15] != a[15]);
`endif
        sb_q.push_back({ovf, full});
        check("idle_ready", {31'd0, in_ready[g]}, 32'd1);
        A = a; B = b; Cin = cin; in_valid[g] = 1'b1;
        tick();
        in_valid[g] = 1'b0;
        A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom);
        lat = 0;
        busy_bad = 1'b0;
        while (!out_valid[g] && lat < 40) begin
            if (in_ready[g]) busy_bad = 1'b1;
            tick();
            lat++;
        end
        if (in_ready[g]) busy_bad = 1'b1;
        check("latency", lat, nslice(g));
        check("busy_not_ready", {31'd0, busy_bad}, 32'd0);
        got = observed(g);
        hold_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid[g] = 1'b1;
            A = 16'($urandom); B = 16'($urandom);
            tick();
            if (observed(g) != got || !out_valid[g] || in_ready[g]) hold_bad = 1'b1;
        end
        in_valid[g] = 1'b0;
        if (hold > 0) check("hold_stable", {31'd0, hold_bad}, 32'd0);
        out_ready[g] = 1'b1;
        e = sb_q.pop_front();
        check("sum", {16'd0, s[g]}, {16'd0, e[15:0]});
        check("cout", {31'd0, cout[g]}, {31'd0, e[16]});
`ifdef MULTI_CYCLE_ADDER_OVF_EN
        check("ovf", {31'd0, v[g]}, {31'd0, e[17]});
`endif
        tick();
        out_ready[g] = 1'b0;
        check("release_valid", {31'd0, out_valid[g]}, 32'd0);
        check("release_ready", {31'd0, in_ready[g]}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        for (int g = 0; g < 3; g++) begin
            in_valid[g]  = 1'b0;
            out_ready[g] = 1'b0;
        end
        tick();
        tick();
        for (int g = 0; g < 3; g++) begin
            check("rst_s", {16'd0, s[g]}, 32'd0);
            check("rst_cout", {31'd0, cout[g]}, 32'd0);
            check("rst_valid", {31'd0, out_valid[g]}, 32'd0);
            check("rst_ready", {31'd0, in_ready[g]}, 32'd1);
        end
        rst_n = 1'b1;
        tick();

        // Directed operations on the DIGIT=4 instance
        run_op(0, 16'hFFFF, 16'h0001, 1'b0, 0);
        run_op(0, 16'h1234, 16'h4321, 1'b1, 0);
        run_op(0, 16'h8000, 16'h8000, 1'b1, 0);
        run_op(0, 16'hABCD, 16'h0F0F, 1'b0, 6);
        run_op(0, 16'h7FFF, 16'h0001, 1'b0, 0);
        run_op(0, 16'h8000, 16'h8000, 1'b0, 1);
        run_op(0, 16'h0000, 16'h0000, 1'b0, 0);
        run_op(0, 16'hFFFF, 16'hFFFF, 1'b1, 0);

        // out_ready while idle is ignored
        out_ready[0] = 1'b1;
        tick();
        tick();
        out_ready[0] = 1'b0;
        check("idle_out_ready_valid", {31'd0, out_valid[0]}, 32'd0);
        check("idle_out_ready_s", {16'd0, s[0]}, 32'h0000FFFF);

        // Asynchronous reset during ADD slice 2
        A = 16'hAAAA; B = 16'h5555; Cin = 1'b0; in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_s", {16'd0, s[0]}, 32'd0);
        check("async_rst_cout", {31'd0, cout[0]}, 32'd0);
        check("async_rst_valid", {31'd0, out_valid[0]}, 32'd0);
        check("async_rst_ready", {31'd0, in_ready[0]}, 32'd1);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid[0]) seen = 1'b1;
        end
        check("no_result_after_rst", {31'd0, seen}, 32'd0);

        for (int i = 0; i < 30; i++)
            run_op(0, 16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 2));
        for (int g = 1; g < 3; g++) begin
            run_op(g, 16'hFFFF, 16'h0001, 1'b0, 0);
            run_op(g, 16'h7FFF, 16'h0001, 1'b0, 0);
            for (int i = 0; i < 200; i++)
                run_op(g, 16'($urandom), 16'($urandom), 1'($urandom), 0);
        end

        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_cycle_adder.md
Name: multi_cycle_adder

Overview:
- Parametrised, digit-serial successor to the single-bit full adder.
- Adds two WIDTH-bit operands plus a carry-in, DIGIT bits per clock, LSB slice first.
- Uses a registered ripple carry between slices.
- valid/ready handshake on input and output, so it drops into pipelined datapaths that need a narrow, area-cheap adder.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits added per cycle; 1 <= DIGIT <= WIDTH.
- NSLICE, WIDTH/DIGIT, derived (localparam), number of add cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands A, B, Cin are valid
- in_ready  output  1  block can accept operands
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry-in to bit 0
- out_valid  output  1  S, Cout hold a completed result
- out_ready  input  1  consumer accepts result
- S  output  WIDTH  sum, registered
- Cout  output  1  carry out of bit WIDTH-1, registered

Interface decision (already decided): one clock; reset is asynchronous and active-low (ports clk and rst_n). Every register is cleared by rst_n low with no clock required.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, S=0, Cout=0, slice counter=0, carry reg=0, operand regs=0.
- States:
  - IDLE: in_ready=1. On in_valid=1, latch A, B, Cin into operand regs and carry reg; counter=0; go to ADD.
  - ADD: in_ready=0, out_valid=0. Each cycle computes slice k = bits [k*DIGIT +: DIGIT] of latched A + latched B + carry reg (DIGIT+1-bit result).
    - Write low DIGIT bits into S slice k; update carry reg with bit DIGIT; counter++.
    - When k = NSLICE-1: Cout <= final carry, go to DONE.
  - DONE: out_valid=1, in_ready=0. S and Cout held stable. On out_ready=1, go to IDLE (out_valid low the next cycle).
- Latency: handshake at edge E0 -> out_valid high after edge E(NSLICE). With defaults, 4 cycles. Minimum accept-to-accept period is NSLICE+2 cycles.
- No input accepted in DONE or ADD; in_valid ignored there. Operand inputs may change freely after acceptance.
- S is updated slice-by-slice during ADD; consumers sample only when out_valid=1. In IDLE, S/Cout retain the last result.
- DIGIT=WIDTH: single ADD cycle; result equals combinational A+B+Cin.
- Wrap-around: sum is modulo 2^WIDTH; overflow appears only on Cout.
- Unsigned arithmetic; Cin added at bit 0 only.
- Reset mid-operation (any state): immediately IDLE with all reset values; partial result discarded; no out_valid pulse.
- out_ready high while not in DONE: ignored.
- Counter width is clog2(NSLICE), minimum 1 bit; never exceeds NSLICE-1.

Optional Feature:
- Macro: MULTI_CYCLE_ADDER_OVF_EN.
- Defined:
  - Adds output port V (1 bit, reset 0) = signed two's-complement overflow.
  - V = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, captured at the last slice.
  - Valid and stable with out_valid; holds like Cout.
- Not defined: no V port, no extra logic; the rest of the behaviour is identical.

Test Plan:
- WIDTH=16, DIGIT=4: A=0xFFFF, B=0x0001, Cin=0, accepted at E0 -> out_valid after E4, S=0x0000, Cout=1; in_ready=0 during E1..E4.
- A=0x1234, B=0x4321, Cin=1 -> S=0x5556, Cout=0. Then A=0x8000, B=0x8000, Cin=1 -> S=0x0001, Cout=1.
- Backpressure: hold out_ready=0 for 6 cycles in DONE -> S, Cout, out_valid stable, in_ready=0, new in_valid ignored. Raise out_ready -> IDLE next cycle, in_ready=1.
- Drop rst_n to 0 during ADD slice 2 (A=0xAAAA, B=0x5555) -> asynchronously S=0, Cout=0, out_valid=0, in_ready=1; no result emitted after release.
- DIGIT=16 and DIGIT=1 builds, 200 random A/B/Cin each -> {Cout,S} == A+B+Cin; latency 1 and 16 cycles respectively.
- With MULTI_CYCLE_ADDER_OVF_EN: 0x7FFF+0x0001 -> V=1, Cout=0. 0xFFFF+0x0001 -> V=0, Cout=1. 0x8000+0x8000 -> V=1, Cout=1.
